// File: rtl/avst_ta_pkg.sv
// avst_ta_pkg: shared widths, limits and helpers for the Avalon-ST timing adapter
package avst_ta_pkg;
  localparam int DROP_CNT_W = 16;
  localparam int MAX_IN_READY_LATENCY = 8;
  function automatic int ta_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/avst_ta_skid_fifo.sv
// avst_ta_skid_fifo: skid storage with pointers, occupancy count and full/empty flags
// Ports: wr_en/wr_data push (taken when not full, or when full with a pop),
// rd_en pops the head, rd_data is the registered head word, count is occupancy.
module avst_ta_skid_fifo
  import avst_ta_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int FIFO_DEPTH = 2,
  localparam int CNT_W = ta_cnt_w(FIFO_DEPTH),
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic push, pop;
  // Explicit compare-and-wrap so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction
  assign full = count_q == CNT_W'(FIFO_DEPTH);
  assign empty = count_q == '0;
  assign pop = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = wr_en && (!full || pop);
  assign rd_data = mem_q[rd_ptr_q];
  assign count = count_q;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_data;
    wr_ptr_d = push ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? inc(rd_ptr_q) : rd_ptr_q;
    count_d = (push && !pop) ? count_q + CNT_W'(1) : (pop && !push) ? count_q - CNT_W'(1) : count_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/avst_rl_timing_adapter.sv
// avst_rl_timing_adapter: ready-latency-N source to ready-latency-0 sink adapter with overflow reporting
// Ports: in_data/in_valid/in_ready (source side, in_ready honoured IN_READY_LATENCY
// cycles later), out_data/out_valid/out_ready (sink side, latency 0), clr_overflow
// clears overflow_sticky (and drop_count), fill_level is registered occupancy.
// Optional macro AVST_TA_DROP_COUNT_EN builds a saturating 16-bit drop counter;
// without it drop_count is tied to zero.
module avst_rl_timing_adapter
  import avst_ta_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int IN_READY_LATENCY = 0,
  parameter int FIFO_DEPTH = IN_READY_LATENCY + 2,
  localparam int CNT_W = ta_cnt_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  clr_overflow,
  output logic                  overflow_sticky,
  output logic [CNT_W-1:0]      fill_level,
  output logic [DROP_CNT_W-1:0] drop_count
);
  if (FIFO_DEPTH < IN_READY_LATENCY + 1 || IN_READY_LATENCY > MAX_IN_READY_LATENCY) begin : g_bad_cfg
    $error("avst_rl_timing_adapter: FIFO_DEPTH must be >= IN_READY_LATENCY+1 and latency <= 8");
  end
  logic full, empty, pop, overflow, sticky_q, sticky_d;
  logic [CNT_W-1:0] count;
  avst_ta_skid_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .wr_en(in_valid),
    .wr_data(in_data),
    .rd_en(pop),
    .rd_data(out_data),
    .count(count),
    .full(full),
    .empty(empty)
  );
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  assign overflow = in_valid && full && !pop;
  // Leave room for every word the source may still launch after ready drops.
  assign in_ready = count <= CNT_W'(FIFO_DEPTH - IN_READY_LATENCY - 1);
  assign fill_level = count;
  assign overflow_sticky = sticky_q;
  always_comb sticky_d = overflow ? 1'b1 : clr_overflow ? 1'b0 : sticky_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sticky_q <= 1'b0;
    else sticky_q <= sticky_d;
  end
`ifdef AVST_TA_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  always_comb drop_d = overflow ? (clr_overflow ? DROP_CNT_W'(1) : (&drop_q ? drop_q : drop_q + DROP_CNT_W'(1))) : clr_overflow ? '0 : drop_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_q <= '0;
    else drop_q <= drop_d;
  end
  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n && overflow) $display("%m: overflow, word dropped at %0t", $time);
  end
`endif
endmodule

// File: tb/tb_avst_rl_timing_adapter.sv
// tb_avst_rl_timing_adapter: directed scoreboard bench for two adapter configurations
module tb_avst_rl_timing_adapter;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;
  logic [7:0] a_in_data, a_out_data, b_in_data, b_out_data;
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_clr, a_sticky;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_clr, b_sticky;
  logic [1:0] a_fill;
  logic [2:0] b_fill;
  logic [15:0] a_drop, b_drop;
  int checks = 0;
  int errors = 0;
  logic [7:0] qa[$], qb[$];
  avst_rl_timing_adapter #(.DATA_W(8), .IN_READY_LATENCY(0), .FIFO_DEPTH(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .clr_overflow(a_clr), .overflow_sticky(a_sticky),
    .fill_level(a_fill), .drop_count(a_drop));
  avst_rl_timing_adapter #(.DATA_W(8), .IN_READY_LATENCY(3), .FIFO_DEPTH(5)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .clr_overflow(b_clr), .overflow_sticky(b_sticky),
    .fill_level(b_fill), .drop_count(b_drop));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic samp;
    @(negedge clk);
  endtask
`ifdef AVST_TA_DROP_COUNT_EN
  localparam logic [31:0] DROP_ONE = 32'd1;
`else
  localparam logic [31:0] DROP_ONE = 32'd0;
`endif
  always @(negedge clk) begin
    if (reset_n && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) check("a_extra", 32'(a_out_data), 32'hDEAD);
      else check("a_data", 32'(a_out_data), 32'(qa.pop_front()));
    end
    if (reset_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) check("b_extra", 32'(b_out_data), 32'hDEAD);
      else check("b_data", 32'(b_out_data), 32'(qb.pop_front()));
    end
  end
  initial begin
    logic [2:0] h;
    int mcnt, k;
    reset_n = 1'b0;
    {a_in_valid, a_out_ready, a_clr, b_in_valid, b_out_ready, b_clr} = '0;
    a_in_data = '0;
    b_in_data = '0;
    repeat (2) samp;
    check("rst_a_valid", 32'(a_out_valid), 0);
    check("rst_a_data", 32'(a_out_data), 0);
    check("rst_a_ready", 32'(a_in_ready), 1);
    check("rst_a_sticky", 32'(a_sticky), 0);
    check("rst_a_fill", 32'(a_fill), 0);
    check("rst_a_drop", 32'(a_drop), 0);
    check("rst_b_ready", 32'(b_in_ready), 1);
    check("rst_b_fill", 32'(b_fill), 0);
    reset_n = 1'b1;
    // streaming through depth 2, latency 0
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      a_in_valid = 1'b1;
      a_in_data = 8'(i);
      qa.push_back(8'(i));
      samp;
      check("a_rdy_stream", 32'(a_in_ready), 1);
      if (i == 0) check("a_no_bypass", 32'(a_out_valid), 0);
    end
    tick;
    a_in_valid = 1'b0;
    samp;
    tick;
    check("a_stream_drained", 32'(qa.size()), 0);
    check("a_sticky_stream", 32'(a_sticky), 0);
    check("a_fill_stream", 32'(a_fill), 0);
    // compliant latency-3 source into depth 5, sink stalled
    b_out_ready = 1'b0;
    h = '0;
    mcnt = 0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      b_in_valid = h[2];
      if (h[2]) begin
        b_in_data = 8'(8'h10 + k);
        qb.push_back(8'(8'h10 + k));
        k++;
      end
      h = {h[1:0], b_in_ready};
      samp;
      check("b_fill_model", 32'(b_fill), 32'(mcnt));
      check("b_rdy_model", 32'(b_in_ready), 32'(mcnt <= 1));
      if (b_in_valid) mcnt++;
    end
    tick;
    b_in_valid = 1'b0;
    samp;
    check("b_fill_full", 32'(b_fill), 5);
    check("b_rdy_full", 32'(b_in_ready), 0);
    check("b_no_overflow", 32'(b_sticky), 0);
    check("b_head", 32'(b_out_data), 32'h10);
    tick;
    b_out_ready = 1'b1;
    repeat (6) tick;
    b_out_ready = 1'b0;
    check("b_drained", 32'(qb.size()), 0);
    check("b_fill_empty", 32'(b_fill), 0);
    check("b_rdy_empty", 32'(b_in_ready), 1);
    // overflow on full depth-2 FIFO
    a_out_ready = 1'b0;
    tick;
    a_in_valid = 1'b1;
    a_in_data = 8'hA0;
    qa.push_back(8'hA0);
    tick;
    a_in_data = 8'hA1;
    qa.push_back(8'hA1);
    tick;
    a_in_data = 8'h03;
    samp;
    check("a_pre_ovf_sticky", 32'(a_sticky), 0);
    check("a_pre_ovf_fill", 32'(a_fill), 2);
    tick;
    a_in_valid = 1'b0;
    samp;
    check("a_ovf_sticky", 32'(a_sticky), 1);
    check("a_ovf_fill", 32'(a_fill), 2);
    check("a_ovf_head", 32'(a_out_data), 32'hA0);
    check("a_ovf_rdy", 32'(a_in_ready), 0);
    check("a_ovf_drop", 32'(a_drop), DROP_ONE);
    tick;
    a_clr = 1'b1;
    samp;
    check("a_clr_pending", 32'(a_sticky), 1);
    tick;
    a_clr = 1'b0;
    samp;
    check("a_clr_done", 32'(a_sticky), 0);
    check("a_clr_drop", 32'(a_drop), 0);
    // full FIFO with simultaneous write and pop
    tick;
    a_in_valid = 1'b1;
    a_in_data = 8'hA2;
    qa.push_back(8'hA2);
    a_out_ready = 1'b1;
    samp;
    tick;
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    samp;
    check("a_sim_fill", 32'(a_fill), 2);
    check("a_sim_sticky", 32'(a_sticky), 0);
    check("a_sim_head", 32'(a_out_data), 32'hA1);
    // overflow in the clear cycle: set wins
    tick;
    a_in_valid = 1'b1;
    a_in_data = 8'h77;
    a_clr = 1'b1;
    tick;
    a_in_valid = 1'b0;
    a_clr = 1'b0;
    samp;
    check("a_set_wins", 32'(a_sticky), 1);
    check("a_set_wins_drop", 32'(a_drop), DROP_ONE);
`ifdef AVST_TA_DROP_COUNT_EN
    tick;
    a_in_valid = 1'b1;
    repeat (70000) tick;
    a_in_valid = 1'b0;
    samp;
    check("a_drop_sat", 32'(a_drop), 32'hFFFF);
    tick;
    a_in_valid = 1'b1;
    a_clr = 1'b1;
    tick;
    a_in_valid = 1'b0;
    a_clr = 1'b0;
    samp;
    check("a_drop_clr_ovf", 32'(a_drop), 1);
    check("a_sticky_clr_ovf", 32'(a_sticky), 1);
`endif
    tick;
    a_clr = 1'b1;
    tick;
    a_clr = 1'b0;
    a_out_ready = 1'b1;
    repeat (3) tick;
    a_out_ready = 1'b0;
    check("a_final_drained", 32'(qa.size()), 0);
    check("a_final_fill", 32'(a_fill), 0);
    check("a_final_sticky", 32'(a_sticky), 0);
    // asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) begin
      tick;
      b_in_valid = 1'b1;
      b_in_data = 8'(8'h30 + i);
      qb.push_back(8'(8'h30 + i));
    end
    tick;
    b_in_valid = 1'b0;
    samp;
    check("b_pre_rst_fill", 32'(b_fill), 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("b_async_valid", 32'(b_out_valid), 0);
    check("b_async_fill", 32'(b_fill), 0);
    check("b_async_data", 32'(b_out_data), 0);
    check("b_async_rdy", 32'(b_in_ready), 1);
    qb.delete();
    qa.delete();
    samp;
    reset_n = 1'b1;
    tick;
    b_in_valid = 1'b1;
    b_in_data = 8'h55;
    qb.push_back(8'h55);
    samp;
    check("b_post_rst_lat0", 32'(b_out_valid), 0);
    tick;
    b_in_valid = 1'b0;
    samp;
    check("b_post_rst_valid", 32'(b_out_valid), 1);
    check("b_post_rst_data", 32'(b_out_data), 32'h55);
    check("b_post_rst_fill", 32'(b_fill), 1);
    tick;
    b_out_ready = 1'b1;
    samp;
    tick;
    b_out_ready = 1'b0;
    check("b_post_rst_drained", 32'(qb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
